fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Controls the instruction-fetch side of the single-cycle core.
- Boot-loads instruction memory from a word stream using a valid/ready handshake.
- Owns the program counter, word-addressed and incrementing by 1.
- Applies stall and branch/jump redirects.
- Raises end_program when the PC runs past the loaded program size, which replaces file-size counting at simulation time.

Parameters:
ADDR_W, 13, word-address width (8192 × 32-bit words = 32 KB)
DATA_W, 32, instruction width

Ports:
clk  in  1  master clock, rising edge
reset  in  1  asynchronous, active-high reset
start_load  in  1  one-cycle pulse; begins a boot load from IDLE or HALT
load_valid  in  1  boot word valid
load_data  in  DATA_W  boot word
load_last  in  1  marks final boot word
load_ready  out  1  sequencer accepts a boot word
imem_we  out  1  instruction memory write enable
imem_waddr  out  ADDR_W  instruction memory write address
imem_wdata  out  DATA_W  instruction memory write data
imem_raddr  out  ADDR_W  fetch address, equal to pc
pc  out  32  current PC, zero-extended
fetch_valid  out  1  imem_raddr is a valid fetch this cycle
stall  in  1  hold pc
redirect_valid  in  1  branch/jump taken
redirect_target  in  32  new word address
prog_size  out  ADDR_W+1  number of loaded words
end_program  out  1  sticky; PC left the program

Behaviour:
- Reset (async, active-high) sets: state=IDLE, pc=0, load count=0, prog_size=0, and load_ready, imem_we, fetch_valid, end_program all 0.
- States are IDLE, LOAD, RUN, HALT.
- IDLE:
  - All outputs are quiescent.
  - start_load → LOAD, with load count cleared and end_program cleared.
- LOAD:
  - load_ready=1.
  - A beat is accepted when load_valid & load_ready. On acceptance, in the same cycle: imem_we=1, imem_waddr=count, imem_wdata=load_data. Then count increments.
  - imem_we is combinational with the accepted beat and is 0 otherwise.
  - Accepting load_last, or accepting the beat at count=2^ADDR_W-1 (memory full, load_last implied), sets prog_size=count+1 and pc=0, and moves to RUN on the next cycle.
  - load_ready=0 once RUN is entered.
  - start_load is ignored in LOAD.
- RUN:
  - fetch_valid=1 and imem_raddr=pc[ADDR_W-1:0].
  - Next-PC priority is: redirect_valid → pc<=redirect_target; else stall → pc holds; else pc<=pc+1.
  - Redirect during stall: the redirect wins.
  - Bounds check uses the full 32-bit comparison pc >= prog_size, with prog_size zero-extended. On a true result: fetch_valid=0 that cycle, end_program<=1, and the state moves to HALT.
  - A redirect to a target >= prog_size halts on the following cycle, when that target is presented.
  - start_load is ignored in RUN.
- HALT:
  - fetch_valid=0, end_program=1 (held), pc frozen.
  - start_load → LOAD, which clears end_program and count.
- A reset asserted mid-LOAD or mid-RUN aborts immediately. prog_size returns to 0, and memory contents are not cleared.
- One fetch issues per cycle; imem read latency is the instruction memory's, not added here.

Optional Feature:
FETCH_SEQ_BREAKPOINT_EN.
- Defined: adds input bp_addr (ADDR_W) and input bp_enable (1).
  - In RUN, when bp_enable and pc==bp_addr and stall=0, the sequencer holds pc and drives fetch_valid=0 for exactly one cycle.
  - Then it proceeds with fetch_valid=1 at the same pc; no re-trigger occurs until pc changes.
  - A redirect during that cycle still wins.
- Undefined: the ports are absent, and behaviour is as above.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (IDLE, LOAD, RUN, HALT);
  - IMEM_ADDR_W=13 and INSTR_W=32;
  - the next-PC select encoding.
- One natural sub-module: fetch_next_pc, a combinational priority mux for redirect/stall/+1. Everything else stays in fetch_sequencer.

Test Plan:
1. Reset mid-RUN at pc=5 → pc=0, state IDLE, fetch_valid=0, end_program=0, prog_size=0, all in the same cycle (async).
2. start_load; 4 beats 0x11,0x22,0x33,0x44, last on 4th, with load_valid gapped by 1 idle cycle → imem_waddr 0,1,2,3 with matching wdata and imem_we only on accepted beats; prog_size=4; RUN with pc 0,1,2,3; at pc=4 fetch_valid=0 and end_program=1.
3. Load 10 words; in RUN hold stall high for 3 cycles at pc=2 → pc stays 2 for 3 cycles, then 3.
4. Stall and redirect_valid in the same cycle at pc=6, target=1 → next pc=1. Separately, redirect to 12 with prog_size=10 → next cycle fetch_valid=0, end_program=1, HALT.
5. In HALT, start_load, then load 2 words → end_program clears on entry to LOAD; prog_size=2; pc restarts at 0. start_load pulsed during RUN → no effect.
6. With FETCH_SEQ_BREAKPOINT_EN defined, bp_addr=3 and bp_enable=1 → fetch_valid low for exactly one cycle at pc=3, then pc 3 fetched, then 4.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM state codes, widths and next-PC select encoding.
package fetch_pkg;

  localparam int unsigned IMEM_ADDR_W = 13;
  localparam int unsigned INSTR_W     = 32;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StLoad = 2'd1;
  localparam state_t StRun  = 2'd2;
  localparam state_t StHalt = 2'd3;

  typedef enum logic [1:0] {
    NpcInc      = 2'd0,
    NpcHold     = 2'd1,
    NpcRedirect = 2'd2
  } npc_sel_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC priority mux: redirect beats stall, stall beats increment.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] next_pc
);

  npc_sel_e sel;

  always_comb begin
    sel = NpcInc;
    if (redirect_valid) begin
      sel = NpcRedirect;
    end else if (stall) begin
      sel = NpcHold;
    end
  end

  always_comb begin
    next_pc = pc + 32'd1;
    unique case (sel)
      NpcRedirect: next_pc = redirect_target;
      NpcHold:     next_pc = pc;
      default:     next_pc = pc + 32'd1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: boot-load, PC ownership, stall/redirect, end-of-program detect.
// Optional breakpoint stall enabled by defining FETCH_SEQ_BREAKPOINT_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = INSTR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_load,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic [ADDR_W-1:0] imem_raddr,
  output logic [31:0]       pc,
  output logic              fetch_valid,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
`ifdef FETCH_SEQ_BREAKPOINT_EN
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_enable,
`endif
  output logic [ADDR_W:0]   prog_size,
  output logic              end_program
);

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W:0]   prog_size_q, prog_size_d;
  logic              end_q, end_d;
  logic              accept, mem_full, out_of_bounds, bp_hit, hold;
  logic [31:0]       npc;

  assign load_ready    = (state_q == StLoad);
  assign accept        = load_valid & load_ready;
  assign mem_full      = &count_q;
  assign out_of_bounds = pc_q >= 32'(prog_size_q);

  assign imem_we     = accept;
  assign imem_waddr  = count_q;
  assign imem_wdata  = load_data;
  assign imem_raddr  = pc_q[ADDR_W-1:0];
  assign pc          = pc_q;
  assign prog_size   = prog_size_q;
  assign end_program = end_q;
  assign fetch_valid = (state_q == StRun) && !out_of_bounds && !bp_hit;

`ifdef FETCH_SEQ_BREAKPOINT_EN
  logic bp_done_q, bp_done_d;

  // One bubble per arrival at bp_addr; re-armed only once pc moves.
  assign bp_hit = (state_q == StRun) && bp_enable && !stall && !bp_done_q &&
                  !out_of_bounds && (pc_q == 32'(bp_addr));

  always_comb begin
    bp_done_d = bp_done_q;
    if (state_q != StRun || pc_d != pc_q) begin
      bp_done_d = 1'b0;
    end else if (bp_hit) begin
      bp_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_done_q <= 1'b0;
    end else begin
      bp_done_q <= bp_done_d;
    end
  end
`else
  assign bp_hit = 1'b0;
`endif

  assign hold = stall | bp_hit;

  fetch_next_pc u_next_pc (
    .pc              (pc_q),
    .stall           (hold),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .next_pc         (npc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    prog_size_d = prog_size_q;
    end_d       = end_q;
    case (state_q)
      StIdle, StHalt: begin
        if (start_load) begin
          state_d = StLoad;
          count_d = '0;
          end_d   = 1'b0;
        end
      end
      StLoad: begin
        if (accept) begin
          count_d = count_q + 1'b1;
          // A beat into the last address ends the load even without load_last.
          if (load_last || mem_full) begin
            prog_size_d = {1'b0, count_q} + 1'b1;
            pc_d        = '0;
            state_d     = StRun;
          end
        end
      end
      StRun: begin
        if (out_of_bounds) begin
          end_d   = 1'b1;
          state_d = StHalt;
        end else begin
          pc_d = npc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      count_q     <= '0;
      prog_size_q <= '0;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      prog_size_q <= prog_size_d;
      end_q       <= end_d;
    end
  end

endmodule
